// File: rtl/pong_pkg.sv
// pong_pkg: shared game state encodings, BCD width and score increment helper.
package pong_pkg;
  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } game_state_t;
  localparam int BCD_W = 4;
  // Two-digit BCD increment that wraps 99 back to 00.
  function automatic logic [2*BCD_W-1:0] bcd_inc(input logic [2*BCD_W-1:0] s);
    logic [BCD_W-1:0] d1, d0;
    d1 = s[2*BCD_W-1:BCD_W];
    d0 = s[BCD_W-1:0];
    return (d0 != 4'd9) ? {d1, d0 + 4'd1} : {(d1 == 4'd9) ? 4'd0 : d1 + 4'd1, 4'd0};
  endfunction
endpackage

// File: rtl/pong_hold_timer.sv
// pong_hold_timer: frame-counting hold timer; timer_up once HOLD_FRAMES frames elapse after load.
module pong_hold_timer #(
  parameter int HOLD_FRAMES = 120
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic refr_tick,
  output logic timer_up
);
  logic [7:0] count;
  assign timer_up = count == 8'd0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) count <= 8'd0;
    else if (load) count <= 8'(HOLD_FRAMES);
    else if (refr_tick && !timer_up) count <= count - 8'd1;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game flow FSM with ball counting and two-digit BCD score.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS       = 3,
  parameter int HOLD_FRAMES = 120
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       btn_tick,
  input  logic             refr_tick,
  input  logic             hit,
  input  logic             miss,
  output logic             graph_still,
  output logic [1:0]       game_state,
  output logic [1:0]       ball_cnt,
  output logic [BCD_W-1:0] score_d1,
  output logic [BCD_W-1:0] score_d0
);
  game_state_t state;
  logic load, timer_up;
  assign load = (state == PLAY) && miss;
  assign graph_still = state != PLAY;
  assign game_state = state;
  pong_hold_timer #(.HOLD_FRAMES(HOLD_FRAMES)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .load(load),
    .refr_tick(refr_tick),
    .timer_up(timer_up)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= NEWGAME;
      ball_cnt <= 2'(BALLS);
      score_d1 <= '0;
      score_d0 <= '0;
    end else begin
      case (state)
        NEWGAME: if (|btn_tick) begin
          state    <= PLAY;
          ball_cnt <= 2'(BALLS - 1);
        end
        // A miss overrides a coincident hit, so the hit never scores.
        PLAY: if (miss) begin
          state    <= (ball_cnt == 2'd0) ? OVER : NEWBALL;
          ball_cnt <= (ball_cnt == 2'd0) ? ball_cnt : ball_cnt - 2'd1;
        end else if (hit) {score_d1, score_d0} <= bcd_inc({score_d1, score_d0});
        NEWBALL: if (timer_up && |btn_tick) state <= PLAY;
        OVER: if (timer_up) begin
          state    <= NEWGAME;
          ball_cnt <= 2'(BALLS);
          score_d1 <= '0;
          score_d0 <= '0;
        end
        default: state <= NEWGAME;
      endcase
    end
endmodule
